// File: rtl/seg_mux_driver_if.sv
// rtl/seg_mux_driver_if.sv - display data inputs and multiplexed pin outputs of seg_mux_driver
interface seg_mux_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank_in;
    logic                    lz_en;
    logic                    load;
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_done;

    modport master (
        output value, dp_in, blank_in, lz_en, load,
        input  seg, dp, an, frame_done
    );

    modport slave (
        input  value, dp_in, blank_in, lz_en, load,
        output seg, dp, an, frame_done
    );
endinterface

// File: rtl/seg_mux_driver.sv
// rtl/seg_mux_driver.sv - multiplexed seven-segment driver with guard interval and double buffering
module seg_mux_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    seg_mux_driver_if.slave    bus
);
    localparam int CNT_MAX = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    typedef enum logic {SHOW, GUARD} state_t;

    state_t                  state;
    logic [IW-1:0]           idx;
    logic [CW-1:0]           cnt;
    logic                    wrap_q;

    // pending buffer, written by load
    logic [4*NUM_DIGITS-1:0] p_value;
    logic [NUM_DIGITS-1:0]   p_dp;
    logic [NUM_DIGITS-1:0]   p_blank;
    logic                    p_lz;
    logic                    p_valid;

    // committed buffer, the one being displayed
    logic [4*NUM_DIGITS-1:0] c_value;
    logic [NUM_DIGITS-1:0]   c_dp;
    logic [NUM_DIGITS-1:0]   c_blank;
    logic                    c_lz;

    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_blank;
    logic                    cur_lead;
    logic                    cur_dark;
    logic                    lz_run;
    logic                    slot_end;
    logic                    wrap;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0: hex_to_seg = 7'h40;
            4'h1: hex_to_seg = 7'h79;
            4'h2: hex_to_seg = 7'h24;
            4'h3: hex_to_seg = 7'h30;
            4'h4: hex_to_seg = 7'h19;
            4'h5: hex_to_seg = 7'h12;
            4'h6: hex_to_seg = 7'h02;
            4'h7: hex_to_seg = 7'h78;
            4'h8: hex_to_seg = 7'h00;
            4'h9: hex_to_seg = 7'h10;
            4'hA: hex_to_seg = 7'h08;
            4'hB: hex_to_seg = 7'h03;
            4'hC: hex_to_seg = 7'h46;
            4'hD: hex_to_seg = 7'h21;
            4'hE: hex_to_seg = 7'h06;
            default: hex_to_seg = 7'h0E;
        endcase
    endfunction

    // Select the digit under the scan pointer; a digit is a leading zero when it and every higher nibble are zero
    always_comb begin
        lz_run    = 1'b1;
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        cur_lead  = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            lz_run = lz_run & (c_value[4*i +: 4] == 4'h0);
            if (idx == IW'(i)) begin
                cur_nib   = c_value[4*i +: 4];
                cur_dp    = c_dp[i];
                cur_blank = c_blank[i];
                cur_lead  = lz_run && (i != 0);
            end
        end
        cur_dark = cur_blank | (c_lz & cur_lead);
    end

    // A slot ends when the pointer is about to move on; the last digit's slot end is the frame boundary
    always_comb begin
        if (state == SHOW) begin
            slot_end = (cnt == SHOW_LAST) && (GUARD_CYCLES == 0);
        end else begin
            slot_end = (cnt == GUARD_LAST);
        end
        wrap = slot_end && (idx == IDX_LAST);
    end

    // Scan FSM, buffer transfer and registered pin outputs; pins reflect the pre-edge scan state
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= SHOW;
            idx            <= '0;
            cnt            <= '0;
            wrap_q         <= 1'b0;
            p_value        <= '0;
            p_dp           <= '0;
            p_blank        <= '0;
            p_lz           <= 1'b0;
            p_valid        <= 1'b0;
            c_value        <= '0;
            c_dp           <= '0;
            c_blank        <= '0;
            c_lz           <= 1'b0;
            bus.an         <= '1;
            bus.seg        <= 7'h7F;
            bus.dp         <= 1'b1;
            bus.frame_done <= 1'b0;
        end else begin
            bus.frame_done <= wrap_q;
            wrap_q         <= wrap;

            if (state == SHOW) begin
                bus.an  <= ~(NUM_DIGITS'(1) << idx);
                bus.seg <= cur_dark ? 7'h7F : hex_to_seg(cur_nib);
                bus.dp  <= cur_dark | ~cur_dp;
            end else begin
                bus.an  <= '1;
                bus.seg <= 7'h7F;
                bus.dp  <= 1'b1;
            end

            case (state)
                SHOW: begin
                    if (cnt == SHOW_LAST) begin
                        cnt <= '0;
                        if (GUARD_CYCLES != 0) begin
                            state <= GUARD;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (cnt == GUARD_LAST) begin
                        cnt   <= '0;
                        state <= SHOW;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase

            if (slot_end) begin
                idx <= wrap ? '0 : idx + 1'b1;
            end

            if (wrap && p_valid) begin
                c_value <= p_value;
                c_dp    <= p_dp;
                c_blank <= p_blank;
                c_lz    <= p_lz;
                p_valid <= 1'b0;
            end

            // Placed after the commit so a load on the boundary edge stays pending for the next frame
            if (bus.load) begin
                p_value <= bus.value;
                p_dp    <= bus.dp_in;
                p_blank <= bus.blank_in;
                p_lz    <= bus.lz_en;
                p_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seg_mux_driver.sv
// tb/tb_seg_mux_driver.sv - scoreboard bench for seg_mux_driver in two configurations
module tb_seg_mux_driver;
    localparam int NA = 4;
    localparam int RA = 4;
    localparam int GA = 1;
    localparam int FA = NA * (RA + GA);
    localparam int NB = 1;
    localparam int RB = 3;
    localparam int GB = 0;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct packed {
        logic [31:0] val;
        logic [7:0]  dp;
        logic [7:0]  blank;
        logic        lz;
    } content_t;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } out_t;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    seg_mux_driver_if #(.NUM_DIGITS(NA)) bus_a ();
    seg_mux_driver_if #(.NUM_DIGITS(NB)) bus_b ();

    seg_mux_driver #(.NUM_DIGITS(NA), .REFRESH_DIV(RA), .GUARD_CYCLES(GA)) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (bus_a.slave)
    );

    seg_mux_driver #(.NUM_DIGITS(NB), .REFRESH_DIV(RB), .GUARD_CYCLES(GB)) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (bus_b.slave)
    );

    always #5 clk = ~clk;

    out_t     qa[$];
    out_t     qb[$];
    int       t_m[2];
    content_t latest[2];
    content_t h1[2];
    content_t h2[2];
    content_t shown[2];
    int       tests = 0;
    int       fails = 0;

    // Reference: edge t after reset sits at position (t-1) mod frame; frame k shows the newest load made before edge k*frame
    task automatic predict(input int i, input int n, input int r, input int g,
                           input logic rst, input logic ld, input content_t in, output out_t o);
        int f, p, k, slot, w;
        logic [31:0] upper;
        logic [3:0]  nib;
        logic        dark;
        content_t    c;
        o.an  = 8'hFF;
        o.seg = 7'h7F;
        o.dp  = 1'b1;
        o.fd  = 1'b0;
        if (rst) begin
            t_m[i]    = 0;
            latest[i] = '0;
            h1[i]     = '0;
            h2[i]     = '0;
            shown[i]  = '0;
            return;
        end
        t_m[i] = t_m[i] + 1;
        f = n * (r + g);
        p = (t_m[i] - 1) % f;
        k = (t_m[i] - 1) / f;
        h2[i] = h1[i];
        h1[i] = latest[i];
        if (p == 0 && k >= 1) shown[i] = h2[i];
        if (ld) latest[i] = in;
        o.fd = (p == 0 && k >= 1);
        slot = p / (r + g);
        w    = p % (r + g);
        if (w < r) begin
            c     = shown[i];
            upper = c.val >> (4 * slot);
            nib   = upper[3:0];
            dark  = c.blank[slot] || (c.lz && slot != 0 && upper == 32'd0);
            o.an  = 8'hFF ^ (8'd1 << slot);
            o.seg = dark ? 7'h7F : SEG_TAB[nib];
            o.dp  = dark ? 1'b1 : ~c.dp[slot];
        end
    endtask

    // Issue one clock of stimulus: predict both DUTs for the coming edge, then advance to the next negedge
    task automatic tick();
        content_t ca, cb;
        out_t     ea, eb;
        if ($urandom_range(0, 4) == 0) begin
            bus_b.load     = 1'b1;
            bus_b.value    = 4'($urandom);
            bus_b.dp_in    = 1'($urandom);
            bus_b.blank_in = 1'($urandom_range(0, 3) == 0);
            bus_b.lz_en    = 1'($urandom);
        end
        ca.val   = 32'(bus_a.value);
        ca.dp    = 8'(bus_a.dp_in);
        ca.blank = 8'(bus_a.blank_in);
        ca.lz    = bus_a.lz_en;
        cb.val   = 32'(bus_b.value);
        cb.dp    = 8'(bus_b.dp_in);
        cb.blank = 8'(bus_b.blank_in);
        cb.lz    = bus_b.lz_en;
        predict(0, NA, RA, GA, rst_a, bus_a.load, ca, ea);
        predict(1, NB, RB, GB, rst_b, bus_b.load, cb, eb);
        qa.push_back(ea);
        qb.push_back(eb);
        @(negedge clk);
        bus_a.load = 1'b0;
        bus_b.load = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic load_a(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b, input logic lz);
        bus_a.value    = v;
        bus_a.dp_in    = d;
        bus_a.blank_in = b;
        bus_a.lz_en    = lz;
        bus_a.load     = 1'b1;
        tick();
    endtask

    // Monitor: one output word per DUT per edge, compared against the head of its queue
    initial begin
        out_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (qa.size() > 0) begin
                e = qa.pop_front();
                a.an  = {4'hF, bus_a.an};
                a.seg = bus_a.seg;
                a.dp  = bus_a.dp;
                a.fd  = bus_a.frame_done;
                tests++;
                if (a !== e) begin
                    fails++;
                    $display("FAIL dut_a @%0t got an=%b seg=%h dp=%b fd=%b want an=%b seg=%h dp=%b fd=%b",
                             $time, a.an[3:0], a.seg, a.dp, a.fd, e.an[3:0], e.seg, e.dp, e.fd);
                end
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                a.an  = {7'h7F, bus_b.an};
                a.seg = bus_b.seg;
                a.dp  = bus_b.dp;
                a.fd  = bus_b.frame_done;
                tests++;
                if (a !== e) begin
                    fails++;
                    $display("FAIL dut_b @%0t got an=%b seg=%h dp=%b fd=%b want an=%b seg=%h dp=%b fd=%b",
                             $time, a.an[0], a.seg, a.dp, a.fd, e.an[0], e.seg, e.dp, e.fd);
                end
            end
        end
    end

    initial begin
        logic [15:0] dec_vals [4];
        dec_vals[0] = 16'h0123;
        dec_vals[1] = 16'h4567;
        dec_vals[2] = 16'h89AB;
        dec_vals[3] = 16'hCDEF;

        bus_a.value = '0; bus_a.dp_in = '0; bus_a.blank_in = '0; bus_a.lz_en = 1'b0; bus_a.load = 1'b0;
        bus_b.value = '0; bus_b.dp_in = '0; bus_b.blank_in = '0; bus_b.lz_en = 1'b0; bus_b.load = 1'b0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        run(3);
        rst_a = 1'b0;
        rst_b = 1'b0;
        run(45);

        for (int v = 0; v < 4; v++) begin
            load_a(dec_vals[v], 4'b0000, 4'b0000, 1'b0);
            run(40);
        end

        run(7);
        load_a(16'h1111, 4'b0000, 4'b0000, 1'b0);
        run(1);
        load_a(16'h2222, 4'b0000, 4'b0000, 1'b0);
        run(45);

        while (((t_m[0] + 1) % FA) != 0) tick();
        load_a(16'h3456, 4'b1000, 4'b0000, 1'b0);
        run(45);

        load_a(16'h0050, 4'b0010, 4'b0000, 1'b1);
        run(45);
        load_a(16'h0050, 4'b0010, 4'b0001, 1'b1);
        run(45);

        while ((t_m[0] % FA) != 14) tick();
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        run(30);

        repeat (500) begin
            if ($urandom_range(0, 9) == 0) begin
                load_a(($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom),
                       4'($urandom), ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000,
                       1'($urandom));
            end else begin
                tick();
            end
        end

        @(posedge clk);
        #2;
        tests++;
        if (qa.size() + qb.size() != 0) begin
            fails++;
            $display("FAIL drain got %0d unconsumed expectations want 0", qa.size() + qb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/seg_mux_driver.md
# seg_mux_driver

Parametrised multiplexed seven-segment display driver: decodes NUM_DIGITS hex nibbles and time-multiplexes them onto one shared active-low cathode bus, cycling active-low anodes at a programmable refresh rate. Adds what the single-digit decoder lacks: digit scanning, anti-ghosting guard interval, per-digit blanking and decimal points, leading-zero suppression, and tear-free double-buffered loading. Sits between system datapath registers and the board display pins.

## Interface
- NUM_DIGITS, 4, number of digits scanned (1..8)
- REFRESH_DIV, 100000, cycles each digit is lit (≥1)
- GUARD_CYCLES, 2, cycles all anodes are off between digits (≥0; 0 removes the guard)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- value  in  4*NUM_DIGITS  hex nibbles; nibble i (bits 4i+3:4i) drives digit i, digit 0 rightmost
- dp_in  in  NUM_DIGITS  1 = decimal point lit for digit i
- blank_in  in  NUM_DIGITS  1 = digit i forced dark (segments and dp)
- lz_en  in  1  1 = leading-zero suppression enabled
- load  in  1  1-cycle strobe: capture value/dp_in/blank_in/lz_en into pending buffer
- seg  out  7  cathodes, active-low, seg[0]=a … seg[6]=g
- dp  out  1  decimal point cathode, active-low
- an  out  NUM_DIGITS  anodes, active-low, at most one low at any time
- frame_done  out  1  1-cycle pulse at the end of each full scan

## Operation
- Three register sets: pending (written by load), committed (being displayed), scan state (state, idx, cnt).
- load=1: pending ← inputs on that edge, pending_valid ← 1. Inputs ignored when load=0.
- Commit occurs only at frame boundary (transition from last digit's slot to digit 0): if pending_valid, committed ← pending, pending_valid ← 0. load and commit on the same edge: commit uses pending contents before this load; new load kept pending for next frame.
- FSM states SHOW, GUARD. SHOW: an[idx]=0, other anodes 1, cnt counts 0..REFRESH_DIV-1; at terminal count → GUARD (or directly to next digit if GUARD_CYCLES=0). GUARD: an all 1, seg=7'h7F, dp=1, cnt counts 0..GUARD_CYCLES-1; at terminal count idx advances, → SHOW.
- idx wraps NUM_DIGITS-1 → 0; wrap edge asserts frame_done for one cycle and performs commit.
- Decode (active-low, {g..a}): 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10,A=08,b=03,C=46,d=21,E=06,F=0E (hex).
- Digit i dark (seg=7F, dp=1, anode still driven low) if committed blank[i], or lz_en and i≠0 and all committed nibbles NUM_DIGITS-1..i are 0. Digit 0 never zero-suppressed. Otherwise dp = ~committed dp[i].

## Timing
- Reset (any cycle, mid-scan included): state=SHOW, idx=0, cnt=0, committed/pending all zero, pending_valid=0; outputs registered: an=all 1, seg=7'h7F, dp=1, frame_done=0.
- First edge after reset release: an=~1 (digit 0), seg shows committed digit 0 ("0" → 7'h40).
- seg, dp, an, frame_done all registered and change on the same edge; no output glitch between anode and cathode.
- Each digit lit exactly REFRESH_DIV cycles; guard exactly GUARD_CYCLES cycles; frame = NUM_DIGITS*(REFRESH_DIV+GUARD_CYCLES) cycles.
- Load-to-display latency: from next frame boundary; worst case one frame + 1 cycle.
- frame_done coincides with the edge where idx returns to 0 (an switches to digit 0 or guard ends).

## Test plan
- Reset/scan: NUM_DIGITS=4, REFRESH_DIV=4, GUARD_CYCLES=1 → an sequence 1110×4, 1111×1, 1101×4, 1111, 1011×4, 1111, 0111×4, 1111, repeat; frame_done every 20 cycles; seg=7'h40 while lit.
- Decode sweep: load value=16'h0123, then 16'h4567, 89AB, CDEF → per-digit seg matches table (e.g. digit 3 of 16'h4567 → 7'h19, digit 0 of 16'hCDEF → 7'h0E).
- Double-buffer: load 16'h1111 mid-frame, then 16'h2222 two cycles later → current frame unchanged, next frame shows all 2 (7'h24); load on commit edge deferred one frame.
- Blanking/dp/LZ: value=16'h0050, lz_en=1, dp_in=4'b0010, blank_in=0 → digit3 7F, digit2 7F, digit1 7'h12 dp=0, digit0 7'h40; blank_in=4'b0001 → digit0 7F.
- Reset mid-operation: assert reset during guard of digit 2 → next edge an=1111, seg=7F; after release scan restarts at digit 0 showing "0000".
- GUARD_CYCLES=0, NUM_DIGITS=1: an constant 0, frame_done every REFRESH_DIV cycles, never all anodes off after first edge.
